uart_rx_ctrl: RTL

Controller that sequences the UART receiver and buffers its output. It generates the oversampling tick and drives the receiver's enable and soft reset. It collects completed bytes into a FIFO, keeps sticky overrun and framing-error flags, and raises an interrupt. It sits between `uart_rx` and the APB register file.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 57 +++++
 rtl/uart_rx_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: controller FSM encoding,
// default frame width and the level-counter width helper.
package uart_pkg;

  // Default frame width; uart_rx and uart_rx_ctrl must agree on it.
  localparam int DATA_BITS_DEF = 8;

  // Receive controller states.
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;

  // Bits needed to count 0..depth inclusive (depth is a power of two).
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead receive FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguished when the address bits are equal.
// head is the oldest entry whenever empty=0 and reads as zero when empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      PRESET,
  input  logic                      push,
  input  logic [DATA_BITS-1:0]      push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [DATA_BITS-1:0]      head,
  output logic                      empty,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 do_push;
  logic                 do_pop;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == (AW+1)'(DEPTH));

  // A pop on empty is ignored; a push on full only lands if a pop frees a slot
  // in the same cycle. Flush overrides both.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || (pop && !empty)) && !flush;

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update: reset and flush return both pointers to zero.
  always_ff @(posedge clk) begin
    if (PRESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences uart_rx (enable / soft reset), generates
// the oversample tick, buffers received bytes and keeps sticky error flags.
//
// Strobe semantics: rx_done is a one-cycle "byte valid" strobe with no
// back-pressure; the byte is taken in RUN/DRAIN if there is room (or a pop
// frees room that cycle), otherwise dropped with overrun. rd_en is a one-cycle
// pop strobe; rd_data is valid whenever fifo_empty=0 and rd_en on empty is a
// no-op.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                           clk,
  input  logic                           PRESET,
  input  logic                           cfg_en,
  input  logic [DIV_W-1:0]               cfg_div,
  input  logic                           cfg_flush,
  input  logic                           err_clr,
  output logic                           s_tick,
  output logic                           rx_en,
  output logic                           rx_rst,
  input  logic [DATA_BITS-1:0]           rx_data,
  input  logic                           rx_done,
  input  logic                           rx_error,
  input  logic                           rx_busy,
  input  logic                           rd_en,
  output logic [DATA_BITS-1:0]           rd_data,
  output logic                           fifo_empty,
  output logic                           fifo_full,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                           overrun,
  output logic                           frame_err,
  output logic                           irq,
  output rx_state_e                      dbg_state
);

  rx_state_e        state;
  rx_state_e        state_next;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick_run;
  logic             capture;
  logic             overrun_set;
  logic             frame_set;

  assign dbg_state = state;

  // Receiver controls decode straight from the state register.
  assign rx_en  = (state == ST_RUN);
  assign rx_rst = (state == ST_OFF) || (state == ST_RECOVER);

  // Tick counter is parked at zero in OFF and ARM so the first RUN period
  // is a full one.
  assign tick_run = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_RECOVER);
  assign s_tick   = tick_run && (tick_cnt == cfg_div);

  // Oversample tick counter: counts 0..cfg_div, wrapping on the tick.
  always_ff @(posedge clk) begin
    if (PRESET || !tick_run) begin
      tick_cnt <= '0;
    end else if (s_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (PRESET) state <= ST_OFF;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:     if (cfg_en) state_next = ST_ARM;
      ST_ARM:     state_next = ST_RUN;
      ST_RUN: begin
        if (rx_error)     state_next = ST_RECOVER;
        else if (!cfg_en) state_next = ST_DRAIN;
      end
      ST_DRAIN:   if (!rx_busy && !rx_done) state_next = ST_OFF;
      ST_RECOVER: state_next = cfg_en ? ST_ARM : ST_OFF;
      default:    state_next = ST_OFF;
    endcase
  end

  // Bytes are accepted only while the receiver is live or finishing a frame.
  assign capture     = rx_done && ((state == ST_RUN) || (state == ST_DRAIN));
  assign overrun_set = capture && fifo_full && !rd_en;
  assign frame_set   = (state == ST_RUN) && rx_error;

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (PRESET) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_set | (overrun   & ~err_clr);
      frame_err <= frame_set   | (frame_err & ~err_clr);
    end
  end

  assign irq = !fifo_empty || overrun || frame_err;

  uart_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .PRESET    (PRESET),
    .push      (capture),
    .push_data (rx_data),
    .pop       (rd_en),
    .flush     (cfg_flush),
    .head      (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule
